// File: rtl/scope_axi_wr_packer.sv
// Packs 14-bit scope samples four per 64-bit word and writes them to DDR as INCR bursts in a circular buffer.
// Optional trigger-address capture is built only when AXI_WR_TRIG_ADDR_EN is defined.
module scope_axi_wr_packer #(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int DW         = 14
) (
    input  logic          axi_clk_i,
    input  logic          axi_rst_i,
    input  logic          cfg_en_i,
    input  logic [31:0]   cfg_start_addr_i,
    input  logic [31:0]   cfg_stop_addr_i,
    input  logic          flush_i,
    input  logic [DW-1:0] dat_i,
    input  logic          dv_i,
    input  logic          trig_i,
    output logic [31:0]   axi_awaddr_o,
    output logic [3:0]    axi_awlen_o,
    output logic [2:0]    axi_awsize_o,
    output logic [1:0]    axi_awburst_o,
    output logic          axi_awvalid_o,
    input  logic          axi_awready_i,
    output logic [63:0]   axi_wdata_o,
    output logic [7:0]    axi_wstrb_o,
    output logic          axi_wlast_o,
    output logic          axi_wvalid_o,
    input  logic          axi_wready_i,
    input  logic          axi_bvalid_i,
    output logic          axi_bready_o,
    input  logic [1:0]    axi_bresp_i,
    output logic [31:0]   wr_addr_o,
    output logic          ovf_o,
    output logic          berr_o,
    output logic          busy_o,
    output logic [31:0]   trig_addr_o,
    output logic [1:0]    dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload stay stable until that edge, ready may change freely.

    localparam int AW_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [47:0]       pack_q, pack_d;
    logic              cfg_en_q;
    logic              drain_q, drain_d;
    logic              ovf_q, ovf_d;
    logic              berr_q, berr_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [3:0]        awlen_q, awlen_d;
    logic [3:0]        beat_q, beat_d;
    logic [AW_W:0]     wr_ptr_q, wr_ptr_d;
    logic [AW_W:0]     rd_ptr_q, rd_ptr_d;
    logic [71:0]       mem_q [FIFO_DEPTH];

    logic [15:0]       sample_ext;
    logic              accept;
    logic              en_rise;
    logic              en_fall;
    logic              flush_req;
    logic [63:0]       word_cur;
    logic [2:0]        n_new;
    logic              push;
    logic [63:0]       push_word;
    logic [7:0]        push_strb;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              wr_en;
    logic              pop;
    logic [71:0]       fifo_head;
    logic [4:0]        avail_beats;
    logic [4:0]        burst_beats;
    logic [31:0]       room_beats;
    logic [31:0]       burst_bytes;
    logic [31:0]       ptr_next;

    assign sample_ext = {{(16-DW){dat_i[DW-1]}}, dat_i};
    assign accept     = dv_i & cfg_en_i;
    assign en_rise    = cfg_en_i & ~cfg_en_q;
    assign en_fall    = ~cfg_en_i & cfg_en_q;
    assign flush_req  = flush_i | en_fall;
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = mem_q[rd_ptr_q[AW_W-1:0]];

    // Packer: the incoming sample is merged first, then a flush decides on the remainder.
    always_comb begin
        word_cur  = {16'h0000, pack_q};
        if (accept) begin
            word_cur[{cnt_q, 4'b0000} +: 16] = sample_ext;
        end
        n_new     = {1'b0, cnt_q} + {2'b00, accept};
        push      = 1'b0;
        push_word = word_cur;
        push_strb = 8'hFF;
        cnt_d     = cnt_q;
        pack_d    = pack_q;
        if (accept && (cnt_q == 2'd3)) begin
            push   = 1'b1;
            cnt_d  = 2'd0;
            pack_d = '0;
        end else if (flush_req && (n_new != 3'd0)) begin
            push   = 1'b1;
            cnt_d  = 2'd0;
            pack_d = '0;
            case (n_new)
                3'd1:    push_strb = 8'h03;
                3'd2:    push_strb = 8'h0F;
                default: push_strb = 8'h3F;
            endcase
        end else if (accept) begin
            cnt_d  = cnt_q + 2'd1;
            pack_d = word_cur[47:0];
        end
    end

    assign wr_en = push & ~fifo_full;
    assign pop   = (state_q == ST_W) & axi_wready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW_W{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW_W{1'b0}}, pop};
    end

    // Burst sizing: a full burst when enough words are queued, otherwise whatever a drain finds,
    // and never past the stop address when an earlier short burst left the pointer misaligned.
    always_comb begin
        avail_beats = (fifo_cnt >= CNT_W'(BURST_LEN)) ? 5'(BURST_LEN) : 5'(fifo_cnt);
        room_beats  = (cfg_stop_addr_i - ptr_q) >> 3;
        burst_beats = avail_beats;
        if ((room_beats != 32'd0) && (room_beats < {27'd0, avail_beats})) begin
            burst_beats = room_beats[4:0];
        end
        burst_bytes = {24'd0, ({1'b0, awlen_q} + 5'd1), 3'b000};
        ptr_next    = ptr_q + burst_bytes;
    end

    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
        berr_d   = berr_q;
        ovf_d    = ovf_q;
        drain_d  = drain_q;

        if (en_rise) begin
            berr_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (push && fifo_full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((fifo_cnt >= CNT_W'(BURST_LEN)) || (drain_q && (fifo_cnt != '0))) begin
                    state_d  = ST_AW;
                    awaddr_d = ptr_q;
                    awlen_d  = 4'(burst_beats - 5'd1);
                end
            end
            ST_AW: begin
                if (axi_awready_i) begin
                    state_d = ST_W;
                    beat_d  = 4'd0;
                end
            end
            ST_W: begin
                if (axi_wready_i) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == awlen_q) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (axi_bvalid_i) begin
                    if (axi_bresp_i != 2'b00) begin
                        berr_d = 1'b1;
                    end
                    ptr_d   = (ptr_next >= cfg_stop_addr_i) ? cfg_start_addr_i : ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (drain_q && (state_q == ST_IDLE) && (fifo_cnt == '0) && !push) begin
            drain_d = 1'b0;
        end
        if (flush_req) begin
            drain_d = 1'b1;
        end
    end

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            pack_q   <= '0;
            cfg_en_q <= 1'b0;
            drain_q  <= 1'b0;
            ovf_q    <= 1'b0;
            berr_q   <= 1'b0;
            ptr_q    <= cfg_start_addr_i;
            awaddr_q <= '0;
            awlen_q  <= '0;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pack_q   <= pack_d;
            cfg_en_q <= cfg_en_i;
            drain_q  <= drain_d;
            ovf_q    <= ovf_d;
            berr_q   <= berr_d;
            ptr_q    <= ptr_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset; contents only become visible through the pointers.
    always_ff @(posedge axi_clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW_W-1:0]] <= {push_strb, push_word};
        end
    end

    assign axi_awaddr_o  = awaddr_q;
    assign axi_awlen_o   = awlen_q;
    assign axi_awsize_o  = 3'd3;
    assign axi_awburst_o = 2'b01;
    assign axi_awvalid_o = (state_q == ST_AW);
    assign axi_wvalid_o  = (state_q == ST_W);
    assign axi_wdata_o   = (state_q == ST_W) ? fifo_head[63:0] : 64'd0;
    assign axi_wstrb_o   = (state_q == ST_W) ? fifo_head[71:64] : 8'd0;
    assign axi_wlast_o   = (state_q == ST_W) && (beat_q == awlen_q);
    assign axi_bready_o  = (state_q == ST_B);
    assign wr_addr_o     = ptr_q;
    assign ovf_o         = ovf_q;
    assign berr_o        = berr_q;
    assign busy_o        = (fifo_cnt != '0) || (cnt_q != 2'd0) || (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

`ifdef AXI_WR_TRIG_ADDR_EN
    logic        trig_seen_q, trig_seen_d;
    logic [31:0] trig_addr_q, trig_addr_d;
    logic [31:0] inflight;
    logic [31:0] words_ahead;
    logic [31:0] trig_calc;

    // Words already popped but not yet counted into the pointer still sit ahead of the sample.
    always_comb begin
        case (state_q)
            ST_W:    inflight = {28'd0, beat_q};
            ST_B:    inflight = {27'd0, ({1'b0, awlen_q} + 5'd1)};
            default: inflight = 32'd0;
        endcase
        words_ahead = 32'(fifo_cnt) + inflight;
        trig_calc   = ptr_q + (words_ahead << 3) + {29'd0, cnt_q, 1'b0};
        if (trig_calc >= cfg_stop_addr_i) begin
            trig_calc = trig_calc - (cfg_stop_addr_i - cfg_start_addr_i);
        end
        trig_seen_d = trig_seen_q & ~en_rise;
        trig_addr_d = trig_addr_q;
        if (trig_i && cfg_en_i && !trig_seen_d) begin
            trig_seen_d = 1'b1;
            trig_addr_d = trig_calc;
        end
    end

    always_ff @(posedge axi_clk_i) begin
        if (axi_rst_i) begin
            trig_seen_q <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            trig_seen_q <= trig_seen_d;
            trig_addr_q <= trig_addr_d;
        end
    end

    assign trig_addr_o = trig_addr_q;
`else
    logic unused_trig;
    assign unused_trig = trig_i;
    assign trig_addr_o = 32'd0;
`endif

endmodule
